psum_rd_seq: RTL and testbench
==============================

# psum_rd_seq

Read-out sequencer for the partial-sum SRAM banks: on a start command it sweeps a block of row addresses and, for each row, reads the `PE_COL` psum banks one at a time. It drives the one-hot bank enable, read address and write-back valid into the psum write-back merge stage, which ORs the bank outputs into one psum stream. It sits between the layer controller (start/done) and the psum SRAM array plus write-back path.

## Interface
- `PE_COL`, 32: number of psum banks, and the width of the one-hot enable.
- `ADDR_W`, 8: psum SRAM row-address width.
- `CLK` in 1: the block's only clock.
- `RST` in 1: asynchronous, active-high reset.
- `i_Start` in 1: pulse that starts a sweep; sampled only in IDLE.
- `i_Base_Addr` in `ADDR_W`: first row address; latched on start.
- `i_Num_Rows` in `ADDR_W`+1: number of rows; latched on start; 0 is allowed.
- `i_Hold` in 1: stall request from downstream; freezes the sweep.
- `o_Psram_En` out `PE_COL`: one-hot bank read enable; all zero when not reading.
- `o_Psram_Addr` out `ADDR_W`: row address presented to all banks.
- `o_Valid_WB_Psum` out 1: high exactly in cycles where `o_Psram_En` is non-zero.
- `o_Busy` out 1: high while in RUN.
- `o_Done` out 1: single-cycle completion pulse.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - On `i_Start`=1: latch base, row count and (if configured) mask; clear the row counter and bank index.
  - Go to RUN if the effective row count is non-zero, otherwise go to DONE.
- **RUN**, each cycle:
  - If `i_Hold`=0: drive `o_Psram_En`=1<<bank, `o_Psram_Addr`=base+row, and `o_Valid_WB_Psum`=1. Then advance the bank index.
  - When the bank index passes the last bank: reset it to the first bank and increment the row counter.
  - After the last bank of the last row: go to DONE.
  - If `i_Hold`=1: enable, valid and the counters are frozen. `o_Psram_En`=0 and `o_Valid_WB_Psum`=0. `o_Psram_Addr` holds its value.
- **DONE**: `o_Done`=1 for one cycle, then go to IDLE.
- `i_Start` is ignored in RUN and DONE; no queuing.
- Address arithmetic is modulo 2^`ADDR_W`, so it wraps silently.
- Sweep order is row-major: all banks of row r before any bank of row r+1.
- `RST` asserted at any time, including mid-sweep:
  - All outputs go to 0 and the FSM goes to IDLE.
  - Any partial sweep is discarded and is not resumed.

## Timing
- All outputs are registered.
- Reset values: `o_Psram_En`=0, `o_Psram_Addr`=0, `o_Valid_WB_Psum`=0, `o_Busy`=0, `o_Done`=0.
- `i_Start` is sampled at edge t.
  - First read: enable is visible in cycle t+1. `o_Busy` rises in t+1.
  - Zero rows: `o_Done` is visible in t+1 and no read is issued.
- Valid is issued in the same cycle as enable. The downstream write-back stage supplies the SRAM-read and merge latency of 2 cycles.
- Throughput is one bank read per non-held cycle.
- The sweep lasts N×`PE_COL`+H cycles, where N is the row count and H is the number of held cycles. `o_Done` follows in the cycle after the last read. `o_Busy` falls in the `o_Done` cycle.
- `i_Hold` takes effect on the same edge at which it is sampled. The read that would have happened in that cycle occurs in the first cycle after hold is released.
- Back-to-back sweeps: a new `i_Start` is accepted no earlier than the cycle after `o_Done`.

## Configuration
- Macro: `PSUM_RD_COL_MASK_EN`.
- **Defined**:
  - Adds port `i_Col_Mask` in `PE_COL`, latched on start.
  - Banks whose mask bit is 0 are skipped and consume no cycle. Within a row, the next read is the next set bit in ascending order.
  - An all-zero mask is treated as zero rows: go straight to DONE.
  - Sweep length is N×popcount(mask)+H.
- **Undefined**: the port is absent and all `PE_COL` banks are read every row.

## Test plan
- **Reset:** assert `RST` mid-simulation with no clock edge → all outputs 0 immediately; FSM in IDLE.
- **Basic sweep:** base=0x10, rows=2 →
  - 64 consecutive reads: `o_Psram_En`=0x1, 0x2, …, 0x8000_0000 at addr 0x10, then the same sequence at 0x11.
  - Valid is high in all 64 cycles.
  - `o_Done` pulses in the cycle after the last read; `o_Busy` is high for exactly 64 cycles.
- **Hold:** base=0, rows=1; hold for 3 cycles while bank 5 is due →
  - Enable and valid are 0 for those 3 cycles.
  - The next read is bank 5 (En=0x20); total sweep is 35 cycles.
- **Zero rows:** rows=0 → `o_Done` pulses in the cycle after start; `o_Busy` never rises; no enable is driven.
- **Wrap:** base=0xFF, rows=2 → 32 reads at 0xFF, then 32 reads at 0x00.
- **Mask and mid-sweep reset** (`PSUM_RD_COL_MASK_EN`):
  - mask=0x8000_0001, rows=1 → exactly 2 reads: En=0x1 then En=0x8000_0000, then `o_Done`.
  - Repeat with rows=4 and assert `RST` after 3 reads → outputs go to 0 and no further reads occur.
  - A new start then runs a full fresh sweep.

Source files
------------

// File: rtl/psum_rd_seq.sv
// Psum SRAM read-out sequencer: sweeps rows x banks row-major, one bank read per non-held cycle.
// Optional column mask (skips banks whose mask bit is 0) enabled by PSUM_RD_COL_MASK_EN.
module psum_rd_seq #(
  parameter int unsigned PE_COL = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_Start,
  input  logic [ADDR_W-1:0] i_Base_Addr,
  input  logic [ADDR_W:0]   i_Num_Rows,
`ifdef PSUM_RD_COL_MASK_EN
  input  logic [PE_COL-1:0] i_Col_Mask,
`endif
  input  logic              i_Hold,
  output logic [PE_COL-1:0] o_Psram_En,
  output logic [ADDR_W-1:0] o_Psram_Addr,
  output logic              o_Valid_WB_Psum,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int unsigned BankW = (PE_COL > 1) ? $clog2(PE_COL) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     rows_q, rows_d;
  logic [ADDR_W:0]     row_q, row_d;
  logic [BankW-1:0]    bank_q, bank_d;
  logic [PE_COL-1:0]   en_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                valid_d, busy_d, done_d;
  logic [PE_COL-1:0]   mask_sel;
`ifdef PSUM_RD_COL_MASK_EN
  logic [PE_COL-1:0]   mask_q, mask_d;
`endif

  logic                issue;
  logic [ADDR_W:0]     cur_row;
  logic [BankW-1:0]    cur_bank;
  logic [BankW-1:0]    first_idx, nxt_idx;
  logic                nxt_found;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    rows_d   = rows_q;
    row_d    = row_q;
    bank_d   = bank_q;
    en_d     = '0;
    addr_d   = o_Psram_Addr;
    valid_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    issue    = 1'b0;
    cur_row  = row_q;
    cur_bank = bank_q;
`ifdef PSUM_RD_COL_MASK_EN
    mask_d   = mask_q;
    mask_sel = (state_q == StIdle) ? i_Col_Mask : mask_q;
`else
    mask_sel = '1;
`endif

    // Lowest set bit of the active mask: first bank of every row.
    first_idx = '0;
    for (int i = int'(PE_COL) - 1; i >= 0; i--) begin
      if (mask_sel[i]) first_idx = BankW'(i);
    end

    unique case (state_q)
      StIdle: begin
        if (i_Start) begin
          base_d = i_Base_Addr;
          rows_d = i_Num_Rows;
          row_d  = '0;
          bank_d = '0;
`ifdef PSUM_RD_COL_MASK_EN
          mask_d = i_Col_Mask;
`endif
          if (i_Num_Rows == '0 || mask_sel == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d  = StRun;
            busy_d   = 1'b1;
            issue    = 1'b1;
            cur_row  = '0;
            cur_bank = first_idx;
          end
        end
      end
      StRun: begin
        // Pointer past the last row means the final read has already been shown.
        if (row_q == rows_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
          issue  = !i_Hold;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Next set mask bit above the bank being read, if any.
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = int'(PE_COL) - 1; i >= 0; i--) begin
      if (mask_sel[i] && (i > int'(cur_bank))) begin
        nxt_found = 1'b1;
        nxt_idx   = BankW'(i);
      end
    end

    if (issue) begin
      en_d    = PE_COL'(1) << cur_bank;
      addr_d  = base_d + cur_row[ADDR_W-1:0];
      valid_d = 1'b1;
      if (nxt_found) begin
        bank_d = nxt_idx;
        row_d  = cur_row;
      end else begin
        bank_d = first_idx;
        row_d  = cur_row + (ADDR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= StIdle;
      base_q          <= '0;
      rows_q          <= '0;
      row_q           <= '0;
      bank_q          <= '0;
      o_Psram_En      <= '0;
      o_Psram_Addr    <= '0;
      o_Valid_WB_Psum <= 1'b0;
      o_Busy          <= 1'b0;
      o_Done          <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      rows_q          <= rows_d;
      row_q           <= row_d;
      bank_q          <= bank_d;
      o_Psram_En      <= en_d;
      o_Psram_Addr    <= addr_d;
      o_Valid_WB_Psum <= valid_d;
      o_Busy          <= busy_d;
      o_Done          <= done_d;
    end
  end

`ifdef PSUM_RD_COL_MASK_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`endif

endmodule

// File: tb/tb_psum_rd_seq.sv
// Directed bench for psum_rd_seq: reset, basic sweep, hold, zero rows, wrap, mid-sweep reset,
// and the column-mask feature when PSUM_RD_COL_MASK_EN is defined.
module tb_psum_rd_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        i_Start = 1'b0;
  logic [7:0]  i_Base_Addr = '0;
  logic [8:0]  i_Num_Rows = '0;
  logic        i_Hold = 1'b0;
`ifdef PSUM_RD_COL_MASK_EN
  logic [31:0] i_Col_Mask = '1;
`endif
  logic [31:0] o_Psram_En;
  logic [7:0]  o_Psram_Addr;
  logic        o_Valid_WB_Psum;
  logic        o_Busy;
  logic        o_Done;

  int n_checks = 0;
  int n_err    = 0;

  psum_rd_seq #(.PE_COL(32), .ADDR_W(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .i_Start        (i_Start),
    .i_Base_Addr    (i_Base_Addr),
    .i_Num_Rows     (i_Num_Rows),
`ifdef PSUM_RD_COL_MASK_EN
    .i_Col_Mask     (i_Col_Mask),
`endif
    .i_Hold         (i_Hold),
    .o_Psram_En     (o_Psram_En),
    .o_Psram_Addr   (o_Psram_Addr),
    .o_Valid_WB_Psum(o_Valid_WB_Psum),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".en"}, o_Psram_En, 0);
    chk({tag, ".valid"}, o_Valid_WB_Psum, 0);
    chk({tag, ".busy"}, o_Busy, 0);
    chk({tag, ".done"}, o_Done, 0);
  endtask

  task automatic chk_read(input string tag, input int bank, input logic [7:0] addr);
    logic [31:0] e;
    e = 32'h1 << bank;
    chk({tag, ".en"}, o_Psram_En, e);
    chk({tag, ".addr"}, o_Psram_Addr, addr);
    chk({tag, ".valid"}, o_Valid_WB_Psum, 1);
    chk({tag, ".busy"}, o_Busy, 1);
    chk({tag, ".done"}, o_Done, 0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done"}, o_Done, 1);
    chk({tag, ".busy"}, o_Busy, 0);
    chk({tag, ".en"}, o_Psram_En, 0);
    chk({tag, ".valid"}, o_Valid_WB_Psum, 0);
    step();
    chk({tag, ".done_pulse"}, o_Done, 0);
  endtask

  task automatic start(input logic [7:0] base, input logic [8:0] rows);
    i_Base_Addr = base;
    i_Num_Rows  = rows;
    i_Start     = 1'b1;
    step();
    i_Start     = 1'b0;
  endtask

  task automatic full_sweep(input string tag, input logic [7:0] base, input int rows);
    logic [7:0] a;
    for (int k = 0; k < rows * 32; k++) begin
      a = base + 8'(k / 32);
      chk_read(tag, k % 32, a);
      step();
    end
    chk_done(tag);
  endtask

  initial begin
    // Reset at time zero
    #1;
    chk_quiet("rst0");
    chk("rst0.addr", o_Psram_Addr, 0);
    #1 RST = 1'b0;
    step();
    chk_quiet("idle");

    // Basic sweep: 64 reads, 0x1..0x8000_0000 at 0x10 then 0x11
    start(8'h10, 9'd2);
    chk("basic.first_en", o_Psram_En, 32'h0000_0001);
    full_sweep("basic", 8'h10, 2);

    // Hold three cycles while bank 5 is due
    start(8'h00, 9'd1);
    for (int k = 0; k < 5; k++) begin
      chk_read("hold.pre", k, 8'h00);
      if (k == 4) i_Hold = 1'b1;
      step();
    end
    for (int h = 0; h < 3; h++) begin
      chk("hold.en", o_Psram_En, 0);
      chk("hold.valid", o_Valid_WB_Psum, 0);
      chk("hold.addr", o_Psram_Addr, 8'h00);
      chk("hold.busy", o_Busy, 1);
      if (h == 2) i_Hold = 1'b0;
      step();
    end
    chk("hold.resume_en", o_Psram_En, 32'h0000_0020);
    for (int k = 5; k < 32; k++) begin
      chk_read("hold.post", k, 8'h00);
      step();
    end
    chk_done("hold");

    // Zero rows: immediate done, no busy, no enable
    start(8'h33, 9'd0);
    chk_done("zero");
    chk_quiet("zero.after");

    // Address wrap 0xFF -> 0x00; a start pulse mid-sweep must be ignored
    start(8'hFF, 9'd2);
    for (int k = 0; k < 64; k++) begin
      chk_read("wrap", k % 32, (k < 32) ? 8'hFF : 8'h00);
      i_Start = (k == 10);
      step();
    end
    i_Start = 1'b0;
    chk_done("wrap");

    // Asynchronous reset mid-sweep, then a fresh sweep
    start(8'h40, 9'd4);
    for (int k = 0; k < 3; k++) begin
      chk_read("mrst.pre", k, 8'h40);
      if (k < 2) step();
    end
    RST = 1'b1;
    #1;
    chk_quiet("mrst.async");
    chk("mrst.addr", o_Psram_Addr, 0);
    step();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("mrst.after");
    end
    start(8'h20, 9'd1);
    full_sweep("fresh", 8'h20, 1);

`ifdef PSUM_RD_COL_MASK_EN
    // Mask with only end banks set: two reads per row
    i_Col_Mask = 32'h8000_0001;
    start(8'h05, 9'd1);
    chk_read("mask.r0", 0, 8'h05);
    step();
    chk_read("mask.r1", 31, 8'h05);
    step();
    chk_done("mask");

    // Same mask, four rows, reset after three reads
    start(8'h05, 9'd4);
    chk_read("mmr.r0", 0, 8'h05);
    step();
    chk_read("mmr.r1", 31, 8'h05);
    step();
    chk_read("mmr.r2", 0, 8'h06);
    RST = 1'b1;
    #1;
    chk_quiet("mmr.async");
    step();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet("mmr.after");
    end
    start(8'h05, 9'd2);
    chk_read("mfresh.r0", 0, 8'h05);
    step();
    chk_read("mfresh.r1", 31, 8'h05);
    step();
    chk_read("mfresh.r2", 0, 8'h06);
    step();
    chk_read("mfresh.r3", 31, 8'h06);
    step();
    chk_done("mfresh");

    // All-zero mask behaves like zero rows
    i_Col_Mask = 32'h0;
    start(8'h00, 9'd3);
    chk_done("mzero");
    i_Col_Mask = '1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
